// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set controller for a 12-hour clock
// Debounced-level buttons are edge-detected, then drive a capture/edit/commit FSM.
module clock_set_ctrl (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       cancel_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_sec_i,
  output logic       Timeset_o,
  output logic [4:0] Hourset_o,
  output logic [5:0] Minset_o,
  output logic [5:0] Secset_o,
  output logic [1:0] field_o,
  output logic       editing_o
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] btn_prev_q;
  logic [3:0] btn_ev_q;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       timeset_q, timeset_d;
  logic [1:0] field_q, field_d;

  logic cancel_ev, mode_ev, inc_ev, dec_ev;
  logic [3:0] btn_now;

  assign btn_now = {cancel_i, mode_i, inc_i, dec_i};
  assign {cancel_ev, mode_ev, inc_ev, dec_ev} = btn_ev_q;

  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    logic [4:0] r;
    if (up) r = (h >= 5'd12) ? 5'd1 : h + 5'd1;
    else    r = (h <= 5'd1 || h > 5'd12) ? 5'd12 : h - 5'd1;
    return r;
  endfunction

  function automatic logic [5:0] sixty_step(input logic [5:0] v, input logic up);
    logic [5:0] r;
    if (up) r = (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  // Events are registered, so the FSM reacts one edge after the rising level is sampled.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_prev_q <= 4'b0;
      btn_ev_q   <= 4'b0;
    end else begin
      btn_prev_q <= btn_now;
      btn_ev_q   <= btn_now & ~btn_prev_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RUN;
      hour_q    <= 5'd12;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      timeset_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      timeset_q <= timeset_d;
      field_q   <= field_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    case (state_q)
      RUN: begin
        if (!cancel_ev && mode_ev) begin
          hour_d  = (cur_hour_i == 5'd0 || cur_hour_i > 5'd12) ? 5'd12 : cur_hour_i;
          min_d   = (cur_min_i > 6'd59) ? 6'd0 : cur_min_i;
          sec_d   = (cur_sec_i > 6'd59) ? 6'd0 : cur_sec_i;
          state_d = SET_HR;
        end
      end
      SET_HR, SET_MIN, SET_SEC: begin
        if (cancel_ev) begin
          state_d = RUN;
        end else if (mode_ev) begin
          case (state_q)
            SET_HR:  state_d = SET_MIN;
            SET_MIN: state_d = SET_SEC;
            default: state_d = COMMIT;
          endcase
        end else if (inc_ev ^ dec_ev) begin
          case (state_q)
            SET_HR:  hour_d = hour_step(hour_q, inc_ev);
            SET_MIN: min_d  = sixty_step(min_q, inc_ev);
            default: sec_d  = sixty_step(sec_q, inc_ev);
          endcase
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    timeset_d = (state_d == COMMIT);
    case (state_d)
      SET_HR:  field_d = 2'd1;
      SET_MIN: field_d = 2'd2;
      SET_SEC: field_d = 2'd3;
      default: field_d = 2'd0;
    endcase
  end

  assign Timeset_o = timeset_q;
  assign Hourset_o = hour_q;
  assign Minset_o  = min_q;
  assign Secset_o  = sec_q;
  assign field_o   = field_q;
  assign editing_o = (state_q == SET_HR) || (state_q == SET_MIN) || (state_q == SET_SEC);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
// Table of capture/edit/commit vectors plus directed multi-cycle sequences.
module tb_clock_set_ctrl;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       mode_i = 1'b0, inc_i = 1'b0, dec_i = 1'b0, cancel_i = 1'b0;
  logic [4:0] cur_hour_i = 5'd1;
  logic [5:0] cur_min_i = 6'd0, cur_sec_i = 6'd0;
  logic       Timeset_o;
  logic [4:0] Hourset_o;
  logic [5:0] Minset_o, Secset_o;
  logic [1:0] field_o;
  logic       editing_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  clock_set_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .mode_i(mode_i), .inc_i(inc_i), .dec_i(dec_i),
    .cancel_i(cancel_i), .cur_hour_i(cur_hour_i), .cur_min_i(cur_min_i), .cur_sec_i(cur_sec_i),
    .Timeset_o(Timeset_o), .Hourset_o(Hourset_o), .Minset_o(Minset_o), .Secset_o(Secset_o),
    .field_o(field_o), .editing_o(editing_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (Timeset_o === 1'b1) pulses++;

  // op: 0 none, 1 inc, 2 dec, 3 inc+dec together
  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    int         op_h, op_m, op_s;
    int         eh, em, es;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // b = {cancel, mode, inc, dec}; high for one cycle, FSM has acted on return
  task automatic press(input logic [3:0] b);
    @(posedge clk_i); #1;
    {cancel_i, mode_i, inc_i, dec_i} = b;
    @(posedge clk_i); #1;
    {cancel_i, mode_i, inc_i, dec_i} = 4'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic apply_op(input int op);
    case (op)
      1: press(4'b0010);
      2: press(4'b0001);
      3: press(4'b0011);
      default: ;
    endcase
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'd3,  6'd15, 6'd42, 0, 0, 0, 3, 15, 42};
    vecs[1] = '{5'd12, 6'd59, 6'd0,  1, 1, 2, 1, 0, 59};
    vecs[2] = '{5'd1,  6'd0,  6'd59, 2, 2, 1, 12, 59, 0};
    vecs[3] = '{5'd0,  6'd60, 6'd63, 0, 0, 0, 12, 0, 0};
    vecs[4] = '{5'd13, 6'd30, 6'd30, 1, 2, 3, 1, 29, 30};
    vecs[5] = '{5'd5,  6'd0,  6'd0,  2, 2, 2, 4, 59, 59};
    vecs[6] = '{5'd11, 6'd58, 6'd1,  1, 1, 2, 12, 59, 0};
    vecs[7] = '{5'd31, 6'd63, 6'd0,  1, 1, 1, 1, 1, 1};

    #2 reset_i = 1'b1;
    #1;
    check("reset_timeset", Timeset_o, 0);
    check("reset_hour", Hourset_o, 12);
    check("reset_min", Minset_o, 0);
    check("reset_sec", Secset_o, 0);
    check("reset_field", field_o, 0);
    check("reset_editing", editing_o, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cur_hour_i = vecs[i].h; cur_min_i = vecs[i].m; cur_sec_i = vecs[i].s;
      p0 = pulses;
      press(4'b0100);
      check($sformatf("v%0d_field_hr", i), field_o, 1);
      check($sformatf("v%0d_editing", i), editing_o, 1);
      apply_op(vecs[i].op_h);
      press(4'b0100);
      check($sformatf("v%0d_field_min", i), field_o, 2);
      apply_op(vecs[i].op_m);
      press(4'b0100);
      check($sformatf("v%0d_field_sec", i), field_o, 3);
      apply_op(vecs[i].op_s);
      press(4'b0100);
      check($sformatf("v%0d_commit_strobe", i), Timeset_o, 1);
      check($sformatf("v%0d_commit_field", i), field_o, 0);
      check($sformatf("v%0d_commit_editing", i), editing_o, 0);
      cur_hour_i = 5'd9; cur_min_i = 6'd9; cur_sec_i = 6'd9;
      ticks(3);
      check($sformatf("v%0d_pulses", i), pulses - p0, 1);
      check($sformatf("v%0d_hour", i), Hourset_o, vecs[i].eh);
      check($sformatf("v%0d_min", i), Minset_o, vecs[i].em);
      check($sformatf("v%0d_sec", i), Secset_o, vecs[i].es);
      check($sformatf("v%0d_timeset_low", i), Timeset_o, 0);
    end

    // Commit latency: event generated at edge N, strobe only in the cycle after N+1
    cur_hour_i = 5'd6; cur_min_i = 6'd7; cur_sec_i = 6'd8;
    press(4'b0100); press(4'b0100); press(4'b0100);
    @(posedge clk_i); #1 mode_i = 1'b1;
    @(posedge clk_i); #1 mode_i = 1'b0;
    check("lat_edge_n", Timeset_o, 0);
    check("lat_edge_n_field", field_o, 3);
    @(posedge clk_i); #1;
    check("lat_edge_n1", Timeset_o, 1);
    @(posedge clk_i); #1;
    check("lat_edge_n2", Timeset_o, 0);
    check("lat_values", {Hourset_o, Minset_o, Secset_o}, {5'd6, 6'd7, 6'd8});

    // Held inc in SET_MIN gives one step, then cancel after two more incs
    cur_hour_i = 5'd4; cur_min_i = 6'd20; cur_sec_i = 6'd10;
    p0 = pulses;
    press(4'b0100); press(4'b0100);
    @(posedge clk_i); #1 inc_i = 1'b1;
    ticks(10);
    inc_i = 1'b0;
    ticks(2);
    check("held_inc_min", Minset_o, 21);
    press(4'b0010); press(4'b0010);
    check("cancel_pre_min", Minset_o, 23);
    press(4'b1000);
    check("cancel_field", field_o, 0);
    check("cancel_editing", editing_o, 0);
    check("cancel_keeps_min", Minset_o, 23);
    ticks(3);
    check("cancel_no_pulse", pulses - p0, 0);

    // Inc/dec in RUN ignored
    press(4'b0010); press(4'b0001);
    check("run_ignore_hour", Hourset_o, 4);
    check("run_ignore_field", field_o, 0);

    // Priority: mode over inc, inc+dec cancel, cancel over mode
    cur_hour_i = 5'd7; cur_min_i = 6'd20; cur_sec_i = 6'd33;
    p0 = pulses;
    press(4'b0100);
    press(4'b0110);
    check("prio_mode_field", field_o, 2);
    check("prio_mode_hour", Hourset_o, 7);
    press(4'b0100);
    press(4'b0011);
    check("prio_incdec_sec", Secset_o, 33);
    check("prio_incdec_field", field_o, 3);
    press(4'b1100);
    check("prio_cancel_field", field_o, 0);
    ticks(3);
    check("prio_no_pulse", pulses - p0, 0);

    // Async reset mid-edit in SET_SEC
    cur_hour_i = 5'd3; cur_min_i = 6'd15; cur_sec_i = 6'd42;
    p0 = pulses;
    press(4'b0100); press(4'b0100); press(4'b0100);
    press(4'b0010);
    @(negedge clk_i); #2 reset_i = 1'b1;
    #1;
    check("rst_mid_out", {Timeset_o, Hourset_o, Minset_o, Secset_o}, {1'b0, 5'd12, 6'd0, 6'd0});
    check("rst_mid_field", field_o, 0);
    check("rst_mid_editing", editing_o, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;
    ticks(4);
    check("rst_mid_no_pulse", pulses - p0, 0);

    // Async reset during COMMIT kills the strobe before it is sampled
    press(4'b0100); press(4'b0100); press(4'b0100);
    p0 = pulses;
    @(posedge clk_i); #1 mode_i = 1'b1;
    @(posedge clk_i); #1 mode_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_commit_entered", Timeset_o, 1);
    #1 reset_i = 1'b1;
    #1;
    check("rst_commit_timeset", Timeset_o, 0);
    check("rst_commit_hour", Hourset_o, 12);
    @(posedge clk_i); #1 reset_i = 1'b0;
    ticks(4);
    check("rst_commit_no_pulse", pulses - p0, 0);
    check("rst_commit_field", field_o, 0);

    // Button held through reset release yields exactly one event
    cur_hour_i = 5'd8;
    mode_i = 1'b1;
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(posedge clk_i); #1;
    check("held_rst_edge1", field_o, 0);
    @(posedge clk_i); #1;
    check("held_rst_edge2", field_o, 1);
    check("held_rst_hour", Hourset_o, 8);
    ticks(5);
    check("held_rst_single", field_o, 1);
    mode_i = 1'b0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
